video_ts_render_gen: RTL and testbench
======================================

Name: video_ts_render_gen

Overview:
Parametrised next-generation TS-line renderer for tiles and sprites. It fetches bitmap words from DRAM and renders pixels into the TS-line buffer. It adds an 8bpp mode alongside 4bpp, a configurable task size, a word FIFO that decouples DRAM delivery from pixel output, and explicit rejection of tasks issued while busy. It sits between the TS sprite/tile engine (task source), the DRAM arbiter, and the TS-line RAM.

Parameters:
SIZE_W, 3, width of x_size; task = x_size+1 render cycles of 8 pixels each, so 2^SIZE_W*8 pixels max
FIFO_DEPTH, 2, depth of the fetched-word FIFO (power of 2, >=2)
TRANSP, 0, pixel index that is treated as transparent (no write)

Ports:
clk  in  1  28MHz video clock
reset  in  1  synchronous, active-high; line-start init
bpp8  in  1  mode for the task: 0=4bpp, 1=8bpp; sampled on accept
x_coord  in  9  TS-line start X
x_size  in  SIZE_W  render cycles minus 1
flip  in  1  X-flip
pal  in  4  palette selector, 4bpp only
tsr_go  in  1  task strobe; accepted only when mem_rdy=1
addr  in  6  8-pixel unit index within the bitmap line
line  in  9  bitmap line
page  in  8  bitmap base page
mem_rdy  out  1  ready to accept a new task
busy  out  1  FIFO non-empty or pixels still pending
ts_waddr  out  9  TS-line write address
ts_wdata  out  8  TS-line write data
ts_we  out  1  TS-line write enable
dram_addr  out  21  DRAM word address
dram_req  out  1  DRAM request
dram_rdata  in  16  DRAM read data
dram_pre_next  in  1  word will be delivered next
dram_next  in  1  dram_rdata valid this cycle
ovf  out  1  sticky: word arrived with FIFO full

Behaviour:
- Reset (any time, including mid-task): mem_rdy=1, busy=0, ts_we=0, ovf=0, dram_req=0 unless tsr_go; FIFO flushed; word counter=0; active/pending task cleared. ts_waddr and ts_wdata are don't-care under reset.
- Accept: acc = tsr_go && mem_rdy. tsr_go with mem_rdy=0 is ignored, with no side effects.
- Word count N: 4bpp 2*(x_size+1); 8bpp 4*(x_size+1). On acc, words_left<=N. It decrements on dram_pre_next while nonzero. mem_rdy = (words_left==0), so it rises at the pre_next of the last word and allows a combinational back-to-back tsr_go.
- dram_req = acc || !mem_rdy.
- Address on acc: 4bpp {page[7:3],line,addr,1'b0}; 8bpp {page[7:4],line,addr,2'b00}. After acc, the offset field increments on dram_next. The offset field is low 7 bits in 4bpp and low 8 bits in 8bpp, and it wraps inside that field with no carry. dram_addr = acc ? addr_in : addr_next, registered each clk.
- Pending task regs, captured on acc: start_x = x_coord + (flip ? {x_size,3'b111} : 0) mod 512; pal; flip; bpp8.
- FIFO entry: {first_of_task, word}. first is set on the first dram_next after acc.
- Render unit pixels per word: 4bpp order [7:4],[3:0],[15:12],[11:8]; 8bpp order [7:0],[15:8].
- Loading a word: the render unit takes a new word when idle or on the last pixel of the current word. Source is the FIFO head if non-empty, else dram_rdata directly when dram_next (bypass, no FIFO write). A simultaneous FIFO write and pop are both performed.
- Latency: pixel 0 is presented in the cycle after its word is loaded, so with the FIFO empty it follows dram_next by exactly 1 clk.
- On loading a first-tagged word: pending -> active; ts_waddr<=start_x. Otherwise ts_waddr steps +1 (flip=0) or -1 (flip=1) per pixel, mod 512.
- Output data: ts_wdata = 4bpp {pal,pix4}; 8bpp pix8. ts_we = pixel valid && pix != TRANSP, comparing the 4-bit nibble against TRANSP[3:0] in 4bpp.
- Overflow: dram_next with FIFO full and no pop -> word dropped, ovf<=1 until reset.
- busy=0 only when the FIFO is empty, no pixel is pending, and mem_rdy=1.

Decomposition:
- Package video_ts_pkg: pixel-order constants, bpp mode enum, address field widths (OFS4_W=7, OFS8_W=8), TS-line width 9.
- Sub-module video_ts_word_fifo: sync FIFO with full/empty flags, simultaneous push/pop, and flush on reset.

Test Plan:
- 4bpp, x=10, x_size=0, flip=0, pal=5, words 0x1234,0x5678 -> writes addr10..17 data 53,54,51,52,57,58,55,56; dram_addr starts {page[7:3],line,addr,0}.
- Same task with flip=1 -> first write at 17, descending to 10; same data order.
- 8bpp, x=0, word 0x00AB -> ts_we at addr0 data AB; addr1 suppressed (transparent); N=4 words fetched for x_size=0.
- 4bpp, x=508, x_size=1 -> writes 508..511 then 0..11; offset 0x7F wraps to 0x00 with no carry into the line bits.
- Back-to-back: tsr_go on the mem_rdy cycle -> no idle DRAM slot; second task's first pixel at its start_x. tsr_go while mem_rdy=0 -> ignored.
- Reset mid-task with FIFO holding 2 words -> next clk ts_we=0, mem_rdy=1, busy=0. Forced dram_next with FIFO full and render stalled -> ovf=1, sticky.

Source files
------------

// File: rtl/video_ts_pkg.sv
// video_ts_pkg: shared widths, pixel-order constants and pixel extraction for the TS-line renderer
package video_ts_pkg;
  localparam int TSL_W = 9;
  localparam int DADDR_W = 21;
  localparam int OFS4_W = 7;
  localparam int OFS8_W = 8;
  typedef enum logic {BPP4 = 1'b0, BPP8 = 1'b1} bpp_e;
  // packed source-nibble index for 4bpp pixels 3..0, source-byte index for 8bpp pixels 1..0
  localparam logic [7:0] NIB4_ORDER = {2'd2, 2'd3, 2'd0, 2'd1};
  localparam logic [1:0] BYTE8_ORDER = 2'b10;
  function automatic logic [7:0] pix_of(input logic [15:0] w, input logic [1:0] idx, input bpp_e m);
    logic [1:0] n;
    logic b;
    n = NIB4_ORDER[{idx, 1'b0} +: 2];
    b = BYTE8_ORDER[idx[0]];
    return m == BPP8 ? w[{b, 3'b000} +: 8] : {4'h0, w[{n, 2'b00} +: 4]};
  endfunction
endpackage

// File: rtl/video_ts_word_fifo.sv
// video_ts_word_fifo: synchronous FIFO with full/empty flags, simultaneous push/pop and reset flush
module video_ts_word_fifo #(
  parameter int W = 17,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/video_ts_render_gen.sv
// video_ts_render_gen: fetches tile/sprite bitmap words from DRAM and renders 4bpp/8bpp pixels into the TS-line buffer
module video_ts_render_gen
  import video_ts_pkg::*;
#(
  parameter int SIZE_W = 3,
  parameter int FIFO_DEPTH = 2,
  parameter logic [7:0] TRANSP = 8'h00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bpp8,
  input  logic [8:0]          x_coord,
  input  logic [SIZE_W-1:0]   x_size,
  input  logic                flip,
  input  logic [3:0]          pal,
  input  logic                tsr_go,
  input  logic [5:0]          addr,
  input  logic [8:0]          line,
  input  logic [7:0]          page,
  output logic                mem_rdy,
  output logic                busy,
  output logic [TSL_W-1:0]    ts_waddr,
  output logic [7:0]          ts_wdata,
  output logic                ts_we,
  output logic [DADDR_W-1:0]  dram_addr,
  output logic                dram_req,
  input  logic [15:0]         dram_rdata,
  input  logic                dram_pre_next,
  input  logic                dram_next,
  output logic                ovf
);
  localparam int WL_W = SIZE_W + 3;
  logic [WL_W-1:0] words_left, sz1, n_words;
  logic acc, first_pend, unused;
  logic [DADDR_W-1:0] addr_r, addr_in, addr_next;
  bpp_e f_bpp8, p_bpp8, a_bpp8;
  logic [TSL_W-1:0] p_start, start_x, waddr;
  logic [3:0] p_pal, a_pal;
  logic p_flip, a_flip;
  logic [15:0] word_r;
  logic [1:0] pidx;
  logic pv, last, can_load, pop, push, bypass, load, full, empty, ovf_r;
  logic [16:0] fifo_dout, ld;
  logic [7:0] pix;
  assign unused = &{1'b0, page[2:0]};
  // fetch side: word countdown, request and address generation
  always_comb begin
    sz1 = WL_W'(x_size) + 1'b1;
    n_words = bpp8 ? sz1 << 2 : sz1 << 1;
    mem_rdy = reset || words_left == '0;
    acc = tsr_go && mem_rdy;
    dram_req = acc || !mem_rdy;
    addr_in = bpp8 ? {page[7:4], line, addr, 2'b00} : {page[7:3], line, addr, 1'b0};
    addr_next = !dram_next ? addr_r :
                f_bpp8 == BPP8 ? {addr_r[DADDR_W-1:OFS8_W], addr_r[OFS8_W-1:0] + 1'b1} :
                                 {addr_r[DADDR_W-1:OFS4_W], addr_r[OFS4_W-1:0] + 1'b1};
    dram_addr = acc ? addr_in : addr_next;
    start_x = x_coord + (flip ? TSL_W'({x_size, 3'b111}) : '0);
  end
  always_ff @(posedge clk)
    if (reset) begin
      words_left <= '0;
      first_pend <= 1'b0;
      addr_r <= '0;
    end else begin
      words_left <= acc ? n_words : dram_pre_next && words_left != '0 ? words_left - 1'b1 : words_left;
      first_pend <= acc ? 1'b1 : dram_next ? 1'b0 : first_pend;
      addr_r <= dram_addr;
    end
  always_ff @(posedge clk)
    if (acc) begin
      f_bpp8 <= bpp_e'(bpp8);
      p_bpp8 <= bpp_e'(bpp8);
      p_start <= start_x;
      p_pal <= pal;
      p_flip <= flip;
    end
  video_ts_word_fifo #(.W(17), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(push),
    .din({first_pend, dram_rdata}),
    .pop(pop),
    .dout(fifo_dout),
    .full(full),
    .empty(empty)
  );
  // render side: a new word is taken when idle or while its predecessor shows its last pixel
  always_comb begin
    last = pv && pidx == (a_bpp8 == BPP8 ? 2'd1 : 2'd3);
    can_load = !pv || last;
    pop = can_load && !empty;
    bypass = can_load && empty && dram_next;
    load = pop || bypass;
    push = dram_next && !bypass && (!full || pop);
    ld = pop ? fifo_dout : {first_pend, dram_rdata};
  end
  always_ff @(posedge clk)
    if (reset) begin
      pv <= 1'b0;
      pidx <= '0;
      ovf_r <= 1'b0;
    end else begin
      if (load) begin
        word_r <= ld[15:0];
        pidx <= '0;
        pv <= 1'b1;
        if (ld[16]) begin
          a_bpp8 <= p_bpp8;
          a_pal <= p_pal;
          a_flip <= p_flip;
          waddr <= p_start;
        end else waddr <= a_flip ? waddr - 1'b1 : waddr + 1'b1;
      end else if (pv && !last) begin
        pidx <= pidx + 1'b1;
        waddr <= a_flip ? waddr - 1'b1 : waddr + 1'b1;
      end else pv <= 1'b0;
      if (dram_next && full && !pop) ovf_r <= 1'b1;
    end
  always_comb begin
    pix = pix_of(word_r, pidx, a_bpp8);
    ts_waddr = waddr;
    ts_wdata = a_bpp8 == BPP8 ? pix : {a_pal, pix[3:0]};
    ts_we = !reset && pv && (a_bpp8 == BPP8 ? pix != TRANSP : pix[3:0] != TRANSP[3:0]);
    busy = !reset && (!empty || pv || !mem_rdy);
    ovf = ovf_r && !reset;
  end
endmodule

// File: tb/tb_video_ts_render_gen.sv
// tb_video_ts_render_gen: directed and random tasks checked against a pixel-list scoreboard model
module tb_video_ts_render_gen;
  typedef struct packed {
    logic b8; logic [8:0] x; logic [2:0] sz; logic fl; logic [3:0] pl;
    logic [5:0] ad; logic [8:0] ln; logic [7:0] pg;
  } task_t;
  typedef struct packed {logic [8:0] a; logic [7:0] d;} wr_t;
  localparam int SH4 [4] = '{4, 0, 12, 8};

  logic clk = 0, reset = 1, bpp8 = 0, flip = 0, tsr_go = 0, dram_pre_next = 0, dram_next = 0;
  logic [8:0] x_coord = 0, line = 0;
  logic [2:0] x_size = 0;
  logic [3:0] pal = 0;
  logic [5:0] addr = 0;
  logic [7:0] page = 0;
  logic [15:0] dram_rdata = 0;
  logic mem_rdy, busy, ts_we, dram_req, ovf;
  logic [8:0] ts_waddr;
  logic [7:0] ts_wdata;
  logic [20:0] dram_addr;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1;
  wr_t exp_q[$];
  wr_t mon_e;
  logic [15:0] dq[$];
  task_t cur, nxt;

  video_ts_render_gen dut (
    .clk(clk), .reset(reset), .bpp8(bpp8), .x_coord(x_coord), .x_size(x_size), .flip(flip),
    .pal(pal), .tsr_go(tsr_go), .addr(addr), .line(line), .page(page), .mem_rdy(mem_rdy),
    .busy(busy), .ts_waddr(ts_waddr), .ts_wdata(ts_wdata), .ts_we(ts_we), .dram_addr(dram_addr),
    .dram_req(dram_req), .dram_rdata(dram_rdata), .dram_pre_next(dram_pre_next),
    .dram_next(dram_next), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic task_t rnd_task();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[40:0];
  endfunction

  function automatic task_t mk(input logic b8, input logic [8:0] x, input logic [2:0] sz,
                               input logic fl, input logic [3:0] pl);
    task_t t;
    t = rnd_task();
    t.b8 = b8; t.x = x; t.sz = sz; t.fl = fl; t.pl = pl;
    return t;
  endfunction

  function automatic logic [20:0] word_addr(input task_t t, input int i);
    logic [20:0] b, m;
    b = t.b8 ? {t.pg[7:4], t.ln, t.ad, 2'b00} : {t.pg[7:3], t.ln, t.ad, 1'b0};
    m = t.b8 ? 21'hFF : 21'h7F;
    return (b & ~m) | ((b + 21'(i)) & m);
  endfunction

  // word i of a task covers pixels i*ppw.. counted from start_x in the flip direction
  task automatic model_word(input task_t t, input int i, input logic [15:0] w);
    int ppw, k;
    logic [8:0] st, a;
    logic [7:0] p;
    ppw = t.b8 ? 2 : 4;
    st = t.x + (t.fl ? 9'(t.sz * 8 + 7) : 9'd0);
    for (int j = 0; j < ppw; j++) begin
      k = i * ppw + j;
      a = t.fl ? st - 9'(k) : st + 9'(k);
      p = t.b8 ? 8'(w >> (8 * j)) : {t.pl, 4'(w >> SH4[j])};
      if (t.b8 ? p != 8'd0 : p[3:0] != 4'd0) exp_q.push_back({a, p});
    end
  endtask

  task automatic drive(input task_t t);
    bpp8 = t.b8; x_coord = t.x; x_size = t.sz; flip = t.fl; pal = t.pl;
    addr = t.ad; line = t.ln; page = t.pg; tsr_go = 1;
  endtask

  task automatic go_task(input task_t t);
    drive(t);
    @(negedge clk);
    chk("acc_mem_rdy", mem_rdy, 1);
    chk("acc_dram_req", dram_req, 1);
    chk("acc_dram_addr", dram_addr, word_addr(t, 0));
    tick;
    tsr_go = 0;
    cur = t;
  endtask

  task automatic deliver(input bit chain, input bit ign);
    int ppw, n, gap;
    logic [15:0] w;
    ppw = cur.b8 ? 2 : 4;
    n = cur.b8 ? 4 * (cur.sz + 1) : 2 * (cur.sz + 1);
    for (int i = 0; i < n; i++) begin
      dram_pre_next = 1;
      @(negedge clk);
      chk("word_dram_addr", dram_addr, word_addr(cur, i));
      chk("fetch_mem_rdy", mem_rdy, 0);
      chk("fetch_dram_req", dram_req, 1);
      chk("fetch_busy", busy, 1);
      tick;
      dram_pre_next = 0;
      dram_next = 1;
      w = dq.size() != 0 ? dq.pop_front() : 16'($urandom);
      dram_rdata = w;
      model_word(cur, i, w);
      if (i == n - 1 && chain) drive(nxt);
      @(negedge clk);
      if (i == n - 1) begin
        chk("last_mem_rdy", mem_rdy, 1);
        if (chain) begin
          chk("b2b_dram_req", dram_req, 1);
          chk("b2b_dram_addr", dram_addr, word_addr(nxt, 0));
        end
      end
      tick;
      dram_next = 0;
      tsr_go = 0;
      if (i == n - 1 && chain) begin
        cur = nxt;
        repeat (2) tick;
      end else if (i < n - 1) begin
        if (ign && i == 0) begin
          drive(rnd_task());
          @(negedge clk);
          chk("ign_mem_rdy", mem_rdy, 0);
          chk("ign_dram_addr", dram_addr, word_addr(cur, 1));
          tick;
          tsr_go = 0;
        end
        gap = ppw - 2 + $urandom_range(0, 2);
        repeat (gap) tick;
      end
    end
  endtask

  task automatic drain;
    repeat (8) tick;
    @(negedge clk);
    chk("drain_pending_writes", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
    chk("idle_mem_rdy", mem_rdy, 1);
    tick;
  endtask

  always @(negedge clk)
    if (chk_en && ts_we) begin
      chk("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("ts_waddr", ts_waddr, mon_e.a);
        chk("ts_wdata", ts_wdata, mon_e.d);
      end
    end

  initial begin
    bit ch;
    repeat (3) tick;
    reset = 0;
    @(negedge clk);
    chk("rst_mem_rdy", mem_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ts_we", ts_we, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dram_req", dram_req, 0);
    tick;
    // directed tasks from the plan
    dq = {16'h1234, 16'h5678};
    go_task(mk(0, 9'd10, 3'd0, 0, 4'd5)); deliver(0, 0); drain;
    dq = {16'h1234, 16'h5678};
    go_task(mk(0, 9'd10, 3'd0, 1, 4'd5)); deliver(0, 0); drain;
    dq = {16'h00AB};
    go_task(mk(1, 9'd0, 3'd0, 0, 4'd0)); deliver(0, 0); drain;
    nxt = mk(0, 9'd508, 3'd1, 0, 4'd9);
    nxt.ad = 6'h3F;
    go_task(nxt); deliver(0, 0); drain;
    // back-to-back issue plus an ignored strobe while busy
    go_task(mk(0, 9'd100, 3'd1, 0, 4'd3));
    nxt = mk(1, 9'd300, 3'd0, 1, 4'd0);
    deliver(1, 1); deliver(0, 0); drain;
    // random tasks with random chaining
    go_task(rnd_task());
    for (int k = 0; k < 40; k++) begin
      ch = (k != 39) && ($urandom_range(0, 1) == 1);
      if (ch) nxt = rnd_task();
      deliver(ch, $urandom_range(0, 3) == 0);
      if (!ch) begin
        drain;
        if (k != 39) go_task(rnd_task());
      end
    end
    // reset mid-task with two words queued behind the render unit
    chk_en = 0;
    go_task(mk(0, 9'd40, 3'd1, 0, 4'd1));
    dram_pre_next = 1; tick;
    dram_next = 1; dram_rdata = 16'h1111; tick;
    dram_rdata = 16'h2222; tick;
    dram_pre_next = 0; dram_rdata = 16'h3333; tick;
    dram_next = 0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_mem_rdy", mem_rdy, 0);
    reset = 1; tick;
    reset = 0;
    @(negedge clk);
    chk("midrst_ts_we", ts_we, 0);
    chk("midrst_mem_rdy", mem_rdy, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf", ovf, 0);
    tick;
    exp_q.delete();
    chk_en = 1;
    repeat (8) tick;
    // overflow: words arrive back-to-back while the render unit is mid-word
    chk_en = 0;
    go_task(mk(0, 9'd200, 3'd1, 0, 4'd2));
    dram_pre_next = 1; tick;
    dram_next = 1;
    repeat (3) begin dram_rdata = 16'($urandom); tick; end
    dram_pre_next = 0; dram_rdata = 16'hBEEF;
    @(negedge clk);
    chk("ovf_before", ovf, 0);
    tick;
    dram_next = 0;
    @(negedge clk);
    chk("ovf_set", ovf, 1);
    repeat (6) tick;
    @(negedge clk);
    chk("ovf_sticky", ovf, 1);
    reset = 1; tick;
    reset = 0;
    @(negedge clk);
    chk("ovf_cleared", ovf, 0);
    tick;
    exp_q.delete();
    chk_en = 1;
    // recovery after reset
    go_task(rnd_task()); deliver(0, 0); drain;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
